// File: rtl/cla_adder_pipe.sv
// ============================================================================
// Module   : cla_adder_pipe
// Brief    : Pipelined carry-lookahead adder, one 4-bit CLA group per stage,
//            valid/ready stream with global stall. Optional subtract mode is
//            enabled by defining CLA_ADDER_SUB_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NG = WIDTH / 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("cla_adder_pipe: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    // One pipeline slot. Operands travel unshifted, so group k always reads
    // bits [4k+3:4k]; 'carry' is the carry into the next group to be computed.
    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             carry;
        logic             ovf;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t st_q [NG];
    stage_t st_d [NG];
    stage_t in_stage;
    logic   adv;
    logic   sub_w;

`ifdef CLA_ADDER_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    // Returns {carry into bit 3, carry out of bit 3, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[3], c[4], p ^ c[3:0]};
    endfunction

    function automatic stage_t stage_step(input stage_t s, input int unsigned k);
        stage_t           r;
        logic [WIDTH-1:0] b_eff;
        logic [5:0]       grp;
        r     = s;
        b_eff = s.b ^ {WIDTH{s.sub}};
        grp   = cla4(s.a[4*k +: 4], b_eff[4*k +: 4], s.carry);
        r.s[4*k +: 4] = grp[3:0];
        r.carry       = grp[4];
        r.ovf         = grp[5] ^ grp[4];
        return r;
    endfunction

    // Subtraction forces the bit-0 carry to 1; a bubble enters as an all-zero slot.
    always_comb begin
        in_stage = '0;
        if (in_valid) begin
            in_stage.valid = 1'b1;
            in_stage.sub   = sub_w;
            in_stage.carry = sub_w | c_in;
            in_stage.a     = a;
            in_stage.b     = b;
        end
    end

    always_comb begin
        adv      = out_ready | ~st_q[NG-1].valid;
        st_d[0]  = stage_step(in_stage, 0);
        for (int k = 1; k < NG; k++) begin
            st_d[k] = stage_step(st_q[k-1], k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NG; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < NG; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = st_q[NG-1].valid;
    assign sum       = st_q[NG-1].s;
    assign c_out     = st_q[NG-1].carry;
    assign ovf       = st_q[NG-1].ovf;

endmodule

`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
// ============================================================================
// Module   : tb_cla_adder_pipe
// Brief    : Directed self-checking bench for cla_adder_pipe (WIDTH=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cla_adder_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
`ifdef CLA_ADDER_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    cla_adder_pipe #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef CLA_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One isolated beat: silent for 3 negedges, valid on the 4th, gone on the 5th.
    task automatic run_single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                              input logic ci, input logic [15:0] es, input logic ec,
                              input logic eo);
        @(negedge clk);
        a = av; b = bv; c_in = ci; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(sum),       32'(es));
        check({tag, "_cout"},  32'(c_out),     32'(ec));
        check({tag, "_ovf"},   32'(ovf),       32'(eo));
        @(negedge clk);
        check({tag, "_one_cycle"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] bb_a [3] = '{16'h1000, 16'h8000, 16'h00FF};
    logic [15:0] bb_b [3] = '{16'h0100, 16'h8000, 16'h0001};
    logic [15:0] bb_s [3] = '{16'h1100, 16'h0000, 16'h0100};
    logic        bb_c [3] = '{1'b0, 1'b1, 1'b0};
    logic        bb_o [3] = '{1'b0, 1'b1, 1'b0};

    logic [15:0] bp_a [3] = '{16'h0001, 16'h00F0, 16'hA000};
    logic [15:0] bp_b [3] = '{16'h0002, 16'h0010, 16'h6000};
    logic [15:0] bp_s [3] = '{16'h0003, 16'h0100, 16'h0000};
    logic        bp_c [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
`ifdef CLA_ADDER_SUB_EN
        sub = 1'b0;
`endif
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(c_out),     32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;

        run_single("basic",   16'h0007, 16'h0003, 1'b0, 16'h000A, 1'b0, 1'b0);
        run_single("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("ovf_cin", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);

        // Back-to-back stream, one result per cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = bb_a[i]; b = bb_b[i]; c_in = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_not_yet", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("b2b%0d_sum", i),   32'(sum),       32'(bb_s[i]));
            check($sformatf("b2b%0d_cout", i),  32'(c_out),     32'(bb_c[i]));
            check($sformatf("b2b%0d_ovf", i),   32'(ovf),       32'(bb_o[i]));
        end
        @(negedge clk);
        check("b2b_drain", 32'(out_valid), 32'd0);

        // Backpressure: first result held three cycles, then the rest in order
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = bp_a[i]; b = bp_b[i]; c_in = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", h),    32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_sum", h),      32'(sum),       32'(bp_s[0]));
            check($sformatf("bp_hold%0d_cout", h),     32'(c_out),     32'(bp_c[0]));
            check($sformatf("bp_hold%0d_in_ready", h), 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", i),    32'(out_valid), 32'd1);
            check($sformatf("bp%0d_sum", i),      32'(sum),       32'(bp_s[i]));
            check($sformatf("bp%0d_cout", i),     32'(c_out),     32'(bp_c[i]));
            check($sformatf("bp%0d_in_ready", i), 32'(in_ready),  32'd1);
        end
        @(negedge clk);
        check("bp_drain", 32'(out_valid), 32'd0);

        // Asynchronous reset with beats in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'h0011; b = 16'h0022; c_in = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_valid",     32'(out_valid), 32'd1);
        check("mid_sum",       32'(sum),       32'h0033);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_sum",       32'(sum),       32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_single("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

`ifdef CLA_ADDER_SUB_EN
        sub = 1'b1;
        run_single("sub_neg", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        sub = 1'b0;
        run_single("add_after_sub", 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
Parametrised, pipelined carry-lookahead adder built from 4-bit CLA groups, with one register stage per group.
- Successor to the fixed 4-bit combinational CLA: generic WIDTH, a valid/ready stream interface, backpressure and an overflow flag.
- Sits in datapaths that need full-throughput wide additions at a clock rate a single-cycle wide carry chain cannot meet.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4
NG, WIDTH/4, derived: number of 4-bit CLA groups = pipeline depth (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry into bit 0
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B+c_in, low WIDTH bits
c_out  output  1  carry out of MSB
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async, rst=1): clear all stage valid bits and all pipeline data registers. Outputs while in reset: out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1.
- Global advance: adv = out_ready | ~out_valid.
  - in_ready = adv (combinational).
  - The whole pipe shifts only when adv=1; when adv=0, every stage holds.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Stage 0 on input transfer:
  - Computes group 0 (bits 3:0) with 4-bit CLA: generate g=a&b, propagate p=a^b, lookahead carries from c_in.
  - Registers sum[3:0], the group carry, and skewed copies of a/b for groups 1..NG-1.
  - Stage valid bit = in_valid when adv=1.
- Stage k (1..NG-1): computes group k from the registered carry of stage k-1 and the skewed operand bits. Already-finished lower sum bits are delayed alongside.
- Output comes from the stage NG-1 registers.
  - c_out = carry out of group NG-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Latency: exactly NG clock edges from input transfer to out_valid=1 when never stalled (NG=4 for WIDTH=16).
- Throughput: one beat per cycle while out_ready=1.
- Bubbles: an input bubble (in_valid=0 with adv=1) propagates as valid=0. Bubbles are not collapsed; no buffering beyond the NG stages.
- Backpressure: out_valid=1 & out_ready=0 holds out_valid, sum, c_out, ovf stable and freezes all stages; in_ready=0 in the same cycle.
- Simultaneous output and input transfer in one cycle: both occur, and the pipe shifts by one.
- Wrap-around: arithmetic is modulo 2^WIDTH, and the carry is reported on c_out.
- Reset mid-operation: all in-flight beats are discarded; no partial result is ever emitted.
- Result data is don't-care while out_valid=0, but must not be X after reset.

Optional Feature:
CLA_ADDER_SUB_EN
- When defined:
  - Adds input port sub (1 bit), sampled with a/b on input transfer.
  - sub=1 computes A + ~B + 1; c_in is ignored and forced to 1 at bit 0.
  - c_out = NOT borrow; ovf = signed subtraction overflow.
  - sub is carried through the skew registers so it aligns per beat.
- When undefined: no sub port; addition only, as described above.

Test Plan:
- WIDTH=16, no stall: a=0x0007, b=0x0003, c_in=0 → after 4 edges, sum=0x000A, c_out=0, ovf=0, out_valid high for 1 cycle.
- Full carry ripple across groups: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Also a=0x7FFF, b=0x0000, c_in=1 → sum=0x8000, c_out=0, ovf=1.
- Back-to-back stream of pairs (0x1000,0x0100), (0x8000,0x8000), (0x00FF,0x0001) on consecutive cycles:
  - Results 0x1100/c0, 0x0000/c1/ovf1, 0x0100/c0 on consecutive cycles.
  - Throughput 1 beat/cycle.
- Backpressure: out_ready=0 for 3 cycles while a result is valid → sum/c_out held, in_ready=0. Afterwards, results emerge in order with none lost or duplicated.
- Reset mid-operation: assert rst asynchronously (between clk edges) with 3 beats in flight → out_valid=0 immediately. After deassert, no stale beat appears; a new beat a=0x0001, b=0x0001 yields 0x0002 after 4 edges.
- With CLA_ADDER_SUB_EN: sub=1, a=0x0003, b=0x0005 → sum=0xFFFE, c_out=0. Also a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1.
